// File: rtl/booth_mul_seq.sv
// booth_mul_seq: radix-2 Booth 32x32 signed multiplier using an external adder; BOOTH_MUL_ZERO_SKIP_EN skips zero operands
module booth_mul_seq (
    input  logic        clk,
    input  logic        clr,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] AddA,
    output logic [31:0] AddB,
    output logic        AddCin,
    input  logic [31:0] AddSum,
    input  logic        AddCout,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [31:0] acc, q, m, p, n_acc, n_q;
    logic [5:0] cnt;
    logic qm1, zero, run, op_add, op_sub, arith, s, accept;
    always_comb begin
        run = state == RUN;
        accept = Start && !run;
        op_add = run && !q[0] && qm1;
        op_sub = run && q[0] && !qm1;
        arith = op_add || op_sub;
        AddA = acc;
        AddB = op_add ? m : op_sub ? ~m : 32'd0;
        AddCin = op_sub;
        p = arith ? AddSum : acc;
        // sign of the true 33-bit sum survives overflow (e.g. subtracting 0x80000000)
        s = arith ? acc[31] ^ AddB[31] ^ AddCout : acc[31];
        n_acc = {s, p[31:1]};
        n_q = {p[0], q[31:1]};
        Busy = run;
        Done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            acc <= '0;
            q <= '0;
            qm1 <= 1'b0;
            m <= '0;
            cnt <= '0;
            zero <= 1'b0;
            Hi <= '0;
            Lo <= '0;
        end else if (accept) begin
            state <= RUN;
            acc <= '0;
            q <= B;
            qm1 <= 1'b0;
            m <= A;
            cnt <= '0;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
            zero <= A == 32'd0 || B == 32'd0;
`else
            zero <= 1'b0;
`endif
        end else if (run && zero) begin
            state <= DONE;
            Hi <= '0;
            Lo <= '0;
        end else if (run) begin
            acc <= n_acc;
            q <= n_q;
            qm1 <= q[0];
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
                state <= DONE;
                Hi <= n_acc;
                Lo <= n_q;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed checks of booth_mul_seq with a behavioural ripple-adder stand-in
module tb_booth_mul_seq;
    logic clk = 1'b0, clr = 1'b1, Start = 1'b0;
    logic [31:0] A = '0, B = '0, AddA, AddB, AddSum, Hi, Lo;
    logic AddCin, AddCout, Busy, Done;
    int checks = 0, errors = 0;
`ifdef BOOTH_MUL_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 32;
`endif
    booth_mul_seq dut (
        .clk(clk), .clr(clr), .Start(Start), .A(A), .B(B),
        .AddA(AddA), .AddB(AddB), .AddCin(AddCin), .AddSum(AddSum), .AddCout(AddCout),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );
    assign {AddCout, AddSum} = {1'b0, AddA} + {1'b0, AddB} + {32'd0, AddCin};
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [63:0] exp, input int inj);
        logic [63:0] prev;
        int n;
        prev = {Hi, Lo};
        @(negedge clk);
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        chk({tag, " busy"}, {63'd0, Busy}, 64'd1);
        n = 0;
        while (!Done && n < 100) begin
            if (n == inj) begin
                A = 32'd9;
                B = 32'd9;
                Start = 1'b1;
            end
            if (n == inj + 1) Start = 1'b0;
            if (n == lat / 2) chk({tag, " hold"}, {Hi, Lo}, prev);
            @(posedge clk);
            #1 n++;
        end
        Start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy_done"}, {63'd0, Busy}, 64'd0);
        chk({tag, " product"}, {Hi, Lo}, exp);
    endtask
    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {Hi, Lo}, 64'd0);
        chk("reset flags", {62'd0, Busy, Done}, 64'd0);
        clr = 1'b0;
        mul("7x6", 32'd7, 32'd6, 32, 64'h0000_0000_0000_002A, -5);
        mul("-3x5", 32'hFFFF_FFFD, 32'd5, 32, 64'hFFFF_FFFF_FFFF_FFF1, -5);
        mul("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 64'd1, -5);
        mul("min2", 32'h8000_0000, 32'h8000_0000, 32, 64'h4000_0000_0000_0000, -5);
        mul("minx1", 32'h8000_0000, 32'd1, 32, 64'hFFFF_FFFF_8000_0000, -5);
        mul("ignore", 32'd3, 32'd4, 32, 64'd12, 10);
        mul("b2b", 32'd2, 32'd2, 32, 64'd4, -5);
        @(negedge clk);
        A = 32'd11;
        B = 32'd13;
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (10) @(posedge clk);
        #1 clr = 1'b1;
        Start = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        Start = 1'b0;
        chk("abort flags", {62'd0, Busy, Done}, 64'd0);
        chk("abort hilo", {Hi, Lo}, 64'd0);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (Done) n++;
        end
        chk("abort no_done", 64'(n), 64'd0);
        mul("5x5", 32'd5, 32'd5, 32, 64'd25, -5);
        mul("0x123", 32'd0, 32'd123, ZLAT, 64'd0, -5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
